// File: rtl/custom_cnt_seq.sv
// ---------------------------------------------------------------------------
// custom_cnt_seq
//   Upstream step sequencer for the custom buffer-use decode path. On a start
//   request it walks cnt through 0..LAST once per pass, for NUM_PASS passes.
//   Downstream stall holds the count. Abort returns the block to idle without
//   a done pulse. A normal finish emits a one-cycle done pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      sequence request; sampled only in IDLE
//   abort      terminate sequence; only acts in RUN and has priority over stall
//   stall      downstream backpressure; holds cnt/pass_idx in RUN
//   cnt        registered step count, 0..LAST
//   cnt_valid  registered; high while the sequencer is in RUN
//   pass_idx   registered pass number, 0..NUM_PASS-1
//   last_step  combinational; final step of the final pass is on cnt
//   busy       registered; state is not IDLE
//   done       registered one-cycle pulse at normal completion
//
// States
//   S_IDLE | waiting for start; cnt/pass_idx parked at 0
//   S_RUN  | stepping cnt, one step per unstalled cycle
//   S_DONE | single-cycle completion state driving the done pulse
// ---------------------------------------------------------------------------
module custom_cnt_seq #(
    parameter int CNT_W    = 5,
    parameter int LAST     = 25,
    parameter int NUM_PASS = 4,
    parameter int PASS_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    output logic [CNT_W-1:0]  cnt,
    output logic              cnt_valid,
    output logic [PASS_W-1:0] pass_idx,
    output logic              last_step,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LAST);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASS - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [PASS_W-1:0]   pass_nxt;
    logic                valid_nxt;
    logic                busy_nxt;
    logic                done_nxt;

    // State register. The registered outputs are loaded from their next-state
    // decodes so that they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pass_idx  <= '0;
            cnt_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pass_idx  <= pass_nxt;
            cnt_valid <= valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pass_nxt  = pass_idx;
        case (state)
            S_IDLE: begin
                cnt_nxt  = '0;
                pass_nxt = '0;
                if (start && !abort) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    pass_nxt  = '0;
                end else if (!stall) begin
                    if (cnt < CNT_LAST) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end else if (pass_idx < PASS_LAST) begin
                        // Explicit wrap at LAST; no bubble between passes.
                        cnt_nxt  = '0;
                        pass_nxt = pass_idx + PASS_W'(1);
                    end else begin
                        state_nxt = S_DONE;
                        cnt_nxt   = '0;
                        pass_nxt  = '0;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                pass_nxt  = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                pass_nxt  = '0;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        valid_nxt = (state_nxt == S_RUN);
        busy_nxt  = (state_nxt != S_IDLE);
        done_nxt  = (state_nxt == S_DONE);
        last_step = cnt_valid && (cnt == CNT_LAST) && (pass_idx == PASS_LAST);
    end

endmodule

// File: doc/custom_cnt_seq.md
Name: custom_cnt_seq

Overview:
- Upstream sequencer for the custom buffer-use decode path.
- Generates the 5-bit step count `cnt`, ranging 0..LAST. The downstream decoder maps `cnt` to 4-bit `buff_use`.
- Runs NUM_PASS passes per start request, with stall backpressure, abort and a one-cycle done pulse.
- Sits between the top-level control FSM (start/abort) and the buff_use decoder / buffer bank (stall).

Parameters:
- CNT_W, 5, width of `cnt`.
- LAST, 25, final count value of a pass. Must be < 2^CNT_W.
- NUM_PASS, 4, passes per start. Must be ≥ 1.
- PASS_W, 2, width of `pass_idx`. Must satisfy 2^PASS_W ≥ NUM_PASS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a sequence. Sampled in IDLE only.
- abort  in  1  terminate the sequence. Effective in RUN only.
- stall  in  1  downstream backpressure. Holds `cnt` while in RUN.
- cnt  out  CNT_W  current step count, registered. Feeds the buff_use decoder.
- cnt_valid  out  1  `cnt` is a live step, i.e. state is RUN.
- pass_idx  out  PASS_W  current pass number, 0..NUM_PASS-1.
- last_step  out  1  combinational: cnt_valid & (cnt==LAST) & (pass_idx==NUM_PASS-1).
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at the end of a sequence.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, cnt=0, pass_idx=0, cnt_valid=0, busy=0, done=0.
  - Reset has immediate effect at any point, including mid-RUN.
  - No done pulse is generated on reset.
- States are IDLE, RUN and DONE. All outputs except last_step are registered.

- IDLE:
  - start=1 & abort=0 → RUN on the next edge, with cnt=0, pass_idx=0, cnt_valid=1.
  - Latency from start to first valid `cnt` is 1 cycle.
  - start=1 & abort=1 in the same cycle: abort wins and the block stays IDLE.
  - stall is ignored.

- RUN, evaluated in priority order:
  1. abort=1 → IDLE. cnt=0, pass_idx=0, cnt_valid=0, no done pulse. Overrides stall.
  2. stall=1 → all state held. cnt, pass_idx and cnt_valid are unchanged.
  3. cnt<LAST → cnt+1.
  4. cnt==LAST & pass_idx<NUM_PASS-1 → cnt wraps to 0 and pass_idx increments. There is no bubble: cnt_valid stays 1.
  5. cnt==LAST & pass_idx==NUM_PASS-1 → DONE. cnt=0, pass_idx=0, cnt_valid=0, done=1.

- DONE:
  - Lasts exactly one cycle, then IDLE unconditionally. done returns to 0 on that transition.
  - start and abort are ignored in DONE. A start must be reasserted in IDLE.
  - busy=1 in DONE.

- Range and throughput:
  - `cnt` never exceeds LAST and never takes values outside 0..LAST while cnt_valid=1.
  - Throughput is 1 step/cycle when unstalled.
  - Unstalled sequence length: NUM_PASS*(LAST+1) valid cycles + 1 DONE cycle.
  - With defaults: 104 valid cycles, then done.

- start held high continuously:
  - Sequences restart only from IDLE.
  - The minimum gap between the last valid step and the next cnt=0 is 2 cycles (DONE, then IDLE).

- stall during the final step: done is deferred until the first unstalled cycle at cnt==LAST of the last pass.
- Width rule: cnt increments in CNT_W bits. The wrap to 0 is explicit at LAST and never relies on natural overflow.

Test Plan:
- Reset mid-sequence:
  - Stimulus: assert rst asynchronously at cnt=13, pass_idx=2.
  - Required: outputs go to 0/IDLE immediately, no done pulse.
  - After release: IDLE, and a start begins again from cnt=0, pass_idx=0.
- Basic sequence, defaults:
  - Stimulus: pulse start in IDLE.
  - Required: the next cycle has cnt=0, cnt_valid=1. cnt runs 0..25 four times, pass_idx 0→3, with no gaps.
  - last_step is high only at pass 3 / cnt 25.
  - done is high exactly 1 cycle after that step, total 104 valid cycles. busy falls the cycle after done.
- Stall:
  - Stimulus: stall for 3 cycles at cnt=7, then at cnt=25 of pass 1.
  - Required: cnt holds at 7 and at 25. The next values are 8, then cnt=0 with pass_idx=2. Total duration is extended by 6 cycles.
- Abort:
  - Stimulus: abort at pass 1, cnt=10, with stall=1 at the same time.
  - Required: the next cycle is IDLE, cnt=0, pass_idx=0, cnt_valid=0, and done never asserts.
  - Also: start and abort together in IDLE → remains IDLE.
- Back-to-back starts:
  - Stimulus: hold start=1 throughout.
  - Required: after done, one IDLE cycle, then cnt=0 and valid again.
  - start asserted during RUN and DONE has no effect.
- Parameter corner:
  - Stimulus: NUM_PASS=1, LAST=5, single start.
  - Required: cnt 0..5 valid, last_step at cnt=5, done on the next cycle.
